// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for branch resolution and the hazard detector.
// Nexttype codes and the 2-bit saturating counter step.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    PCPlus4     = 2'b00,
    Branch      = 2'b01,
    BranchWrong = 2'b10,
    Jump        = 2'b11
  } nexttype_e;

  localparam logic [1:0] CNT_MAX = 2'b11;
  localparam logic [1:0] CNT_MIN = 2'b00;

  function automatic logic [1:0] cnt_step(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] r;
    r = c;
    if (taken) begin
      if (c != CNT_MAX) r = c + 2'd1;
    end else begin
      if (c != CNT_MIN) r = c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side lookup, EX-side resolution and statistics bundle.
// master drives instruction info, slave is the resolve unit.
interface branch_resolve_unit_if #(
  parameter int STAT_WIDTH = 16
);
  logic [31:0]           if_pc;
  logic                  if_pred_taken;
  logic                  ex_valid;
  logic                  ex_is_branch;
  logic                  ex_is_jump;
  logic                  ex_taken;
  logic                  ex_pred_taken;
  logic [31:0]           ex_pc;
  logic [31:0]           ex_target;
  logic [1:0]            nexttype;
  logic [31:0]           redirect_pc;
  logic [STAT_WIDTH-1:0] branch_count;
  logic [STAT_WIDTH-1:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_is_branch,
    output ex_is_jump, ex_taken, ex_pred_taken,
    output ex_pc, ex_target,
    input  if_pred_taken, nexttype, redirect_pc,
    input  branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch,
    input  ex_is_jump, ex_taken, ex_pred_taken,
    input  ex_pc, ex_target,
    output if_pred_taken, nexttype, redirect_pc,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit_bht_counter_array.sv
// Branch history table of 2-bit saturating counters.
// Combinational read, synchronous saturating update and reset.
module bht_counter_array
  import branch_resolve_unit_pkg::*;
#(
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_cnt_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);
  localparam int N = 1 << IDX_BITS;

  logic [N-1:0][1:0] tbl_q;
  logic [N-1:0][1:0] tbl_d;

  // read returns the stored value; no write bypass
  assign rd_cnt_o = tbl_q[rd_idx_i];

  // next table: step one counter on an update
  always_comb begin
    tbl_d = tbl_q;
    if (wr_en_i) begin
      tbl_d[wr_idx_i] = cnt_step(tbl_q[wr_idx_i], wr_taken_i);
    end
  end

  // table register, reset wins over any update
  always_ff @(posedge clk) begin
    if (rst) tbl_q <= {N{CNT_INIT}};
    else     tbl_q <= tbl_d;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution with BHT prediction and statistics.
// Nexttype and redirect are combinational from EX inputs.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         BHT_INDEX_BITS = 4,
  parameter logic [1:0] CNT_INIT       = 2'b01,
  parameter int         STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);
  localparam int IDX_HI = BHT_INDEX_BITS + 1;
  localparam logic [STAT_WIDTH-1:0] SMAX =
    {STAT_WIDTH{1'b1}};

  logic [BHT_INDEX_BITS-1:0] rd_idx;
  logic [BHT_INDEX_BITS-1:0] wr_idx;
  logic [1:0]                rd_cnt;
  logic [31:0]               pc_plus4;
  logic                      sel_jump;
  logic                      sel_ok;
  logic                      sel_wrong;
  logic                      upd;
  nexttype_e                 nt;
  logic [31:0]               redir;
  logic [STAT_WIDTH-1:0]     bcnt_q, bcnt_d;
  logic [STAT_WIDTH-1:0]     mcnt_q, mcnt_d;
  logic                      unused_pc_bits;

  assign rd_idx   = bus.if_pc[IDX_HI:2];
  assign wr_idx   = bus.ex_pc[IDX_HI:2];
  assign pc_plus4 = bus.ex_pc + 32'd4;

  assign unused_pc_bits =
    ^{bus.if_pc[31:IDX_HI+1], bus.if_pc[1:0]};

  assign sel_jump  = bus.ex_valid & bus.ex_is_jump;
  assign upd       = bus.ex_valid & bus.ex_is_branch
                   & ~bus.ex_is_jump;
  assign sel_ok    = upd
                   & (bus.ex_taken == bus.ex_pred_taken);
  assign sel_wrong = upd
                   & (bus.ex_taken != bus.ex_pred_taken);

  bht_counter_array #(
    .IDX_BITS (BHT_INDEX_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (rd_idx),
    .rd_cnt_o   (rd_cnt),
    .wr_en_i    (upd),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (bus.ex_taken)
  );

  assign bus.if_pred_taken = rd_cnt[1];

  // resolution: select code and fetch redirect
  always_comb begin
    nt    = PCPlus4;
    redir = pc_plus4;
    unique case (1'b1)
      sel_jump: begin
        nt    = Jump;
        redir = bus.ex_target;
      end
      sel_ok: begin
        nt    = Branch;
      end
      sel_wrong: begin
        nt = BranchWrong;
        if (bus.ex_taken) redir = bus.ex_target;
      end
      default: ;
    endcase
  end

  assign bus.nexttype    = nt;
  assign bus.redirect_pc = redir;

  // saturating statistics next-state
  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (upd && bcnt_q != SMAX) bcnt_d = bcnt_q + 1'b1;
    if (sel_wrong && mcnt_q != SMAX) mcnt_d = mcnt_q + 1'b1;
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign bus.branch_count     = bcnt_q;
  assign bus.mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: vector table, random
// stimulus against a reference model, saturation and reset.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_resolve_unit_if #(.STAT_WIDTH(16)) bus ();

  branch_resolve_unit #(
    .BHT_INDEX_BITS (4),
    .CNT_INIT       (2'b01),
    .STAT_WIDTH     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m_bht [16];
  int m_bc;
  int m_mc;

  typedef struct {
    logic        r;
    logic        v;
    logic        br;
    logic        jp;
    logic        tk;
    logic        pd;
    logic [31:0] ipc;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  e_nt;
    logic [31:0] e_rd;
    logic        e_pred;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  // drive one cycle, check comb outputs, then clock the model
  task automatic step(input logic r, v, br, jp, tk, pd,
                      input logic [31:0] ipc, pc, tgt);
    logic [1:0]  e_nt;
    logic [31:0] e_rd;
    logic [31:0] p4;
    int          ri;
    int          wi;
    rst              = r;
    bus.ex_valid     = v;
    bus.ex_is_branch = br;
    bus.ex_is_jump   = jp;
    bus.ex_taken     = tk;
    bus.ex_pred_taken = pd;
    bus.if_pc        = ipc;
    bus.ex_pc        = pc;
    bus.ex_target    = tgt;
    #1;
    p4   = pc + 32'd4;
    e_nt = 2'd0;
    e_rd = p4;
    if (v && jp) begin
      e_nt = 2'd3;
      e_rd = tgt;
    end else if (v && br) begin
      if (tk == pd) e_nt = 2'd1;
      else begin
        e_nt = 2'd2;
        if (tk) e_rd = tgt;
      end
    end
    ri = int'(ipc[5:2]);
    wi = int'(pc[5:2]);
    chk("nexttype", 32'(bus.nexttype), 32'(e_nt));
    chk("redirect_pc", bus.redirect_pc, e_rd);
    chk("if_pred_taken", 32'(bus.if_pred_taken),
        (m_bht[ri] >= 2) ? 32'd1 : 32'd0);
    chk("branch_count", 32'(bus.branch_count), m_bc);
    chk("mispredict_count", 32'(bus.mispredict_count), m_mc);
    @(posedge clk);
    if (r) model_reset();
    else if (v && br && !jp) begin
      if (tk) m_bht[wi] = (m_bht[wi] == 3) ? 3 : m_bht[wi] + 1;
      else    m_bht[wi] = (m_bht[wi] == 0) ? 0 : m_bht[wi] - 1;
      if (m_bc < 65535) m_bc++;
      if (tk != pd && m_mc < 65535) m_mc++;
    end
    #1;
  endtask

  task automatic addv(input logic r, v, br, jp, tk, pd,
                      input logic [31:0] ipc, pc, tgt,
                      input logic [1:0] e_nt,
                      input logic [31:0] e_rd,
                      input logic e_pred);
    vec_t x;
    x = '{r, v, br, jp, tk, pd, ipc, pc, tgt,
          e_nt, e_rd, e_pred};
    vt.push_back(x);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jump = 1'b0;
    bus.ex_taken = 1'b0;
    bus.ex_pred_taken = 1'b0;
    bus.if_pc = 32'h0040_0000;
    bus.ex_pc = 32'h0040_0000;
    bus.ex_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    addv(0,0,0,0,0,0, 32'h00400000, 32'h00400000,
         32'h0, 2'd0, 32'h00400004, 0);
    addv(0,1,1,0,1,0, 32'h00400000, 32'h00400010,
         32'h00400040, 2'd2, 32'h00400040, 0);
    addv(0,1,1,0,1,1, 32'h00400010, 32'h00400010,
         32'h00400040, 2'd1, 32'h00400014, 1);
    addv(0,1,1,0,1,1, 32'h00400010, 32'h00400010,
         32'h00400040, 2'd1, 32'h00400014, 1);
    addv(0,1,1,0,1,1, 32'h00400010, 32'h00400010,
         32'h00400040, 2'd1, 32'h00400014, 1);
    addv(0,1,1,0,0,1, 32'h00400010, 32'h00400010,
         32'h00400040, 2'd2, 32'h00400014, 1);
    addv(0,1,1,1,1,0, 32'h00400010, 32'h00400020,
         32'h00401000, 2'd3, 32'h00401000, 1);
    addv(0,1,1,0,0,1, 32'h00400010, 32'h00400010,
         32'h00400040, 2'd2, 32'h00400014, 1);
    addv(0,0,0,0,0,0, 32'h00400010, 32'h00400100,
         32'h0, 2'd0, 32'h00400104, 0);
    addv(0,1,1,0,0,1, 32'h00000000, 32'hFFFFFFFC,
         32'h00001000, 2'd2, 32'h00000000, 0);
    addv(0,1,0,0,0,0, 32'hFFFFFFFC, 32'h00400200,
         32'h0, 2'd0, 32'h00400204, 0);
    addv(0,1,0,1,0,0, 32'h00400010, 32'h00400300,
         32'h00400000, 2'd3, 32'h00400000, 0);
    addv(0,0,1,1,1,0, 32'h00400010, 32'h00400020,
         32'h00401000, 2'd0, 32'h00400024, 0);

    foreach (vt[i]) begin
      vec_t x;
      x = vt[i];
      bus.if_pc = x.ipc;
      bus.ex_valid = x.v;
      bus.ex_is_branch = x.br;
      bus.ex_is_jump = x.jp;
      bus.ex_taken = x.tk;
      bus.ex_pred_taken = x.pd;
      bus.ex_pc = x.pc;
      bus.ex_target = x.tgt;
      #1;
      chk($sformatf("vec%0d_nt", i), 32'(bus.nexttype),
          32'(x.e_nt));
      chk($sformatf("vec%0d_rd", i), bus.redirect_pc, x.e_rd);
      chk($sformatf("vec%0d_pred", i),
          32'(bus.if_pred_taken), 32'(x.e_pred));
      step(x.r, x.v, x.br, x.jp, x.tk, x.pd,
           x.ipc, x.pc, x.tgt);
    end
    chk("vec_branch_count", 32'(bus.branch_count), 32'd7);
    chk("vec_mispredict_count",
        32'(bus.mispredict_count), 32'd4);
    bus.if_pc = 32'h00400010;
    #1;
    chk("after_same_cycle_pred", 32'(bus.if_pred_taken), 32'd0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc;
      logic [31:0] ipc;
      pc  = 32'h00400000 | (32'($urandom_range(0, 15)) << 2);
      ipc = 32'h00400000 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFFFFFC;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 5) == 0),
           1'($urandom), 1'($urandom),
           ipc, pc, $urandom);
    end

    for (int n = 0; n < 65540; n++) begin
      step(0, 1, 1, 0, 1, 0, 32'h00400020, 32'h00400020,
           32'h00400080);
    end
    chk("sat_mispredict", 32'(bus.mispredict_count),
        32'h0000FFFF);
    chk("sat_branch", 32'(bus.branch_count), 32'h0000FFFF);
    step(0, 1, 1, 0, 1, 0, 32'h00400020, 32'h00400020,
         32'h00400080);
    chk("sat_hold", 32'(bus.mispredict_count), 32'h0000FFFF);

    step(0, 1, 1, 0, 1, 1, 32'h00400010, 32'h00400010,
         32'h00400040);
    step(0, 1, 1, 0, 1, 1, 32'h00400010, 32'h00400010,
         32'h00400040);
    step(1, 1, 1, 0, 1, 0, 32'h00400010, 32'h00400010,
         32'h00400040);
    chk("rst_branch_count", 32'(bus.branch_count), 32'd0);
    chk("rst_mispredict_count",
        32'(bus.mispredict_count), 32'd0);
    chk("rst_pred_idx4", 32'(bus.if_pred_taken), 32'd0);
    step(0, 1, 1, 0, 1, 0, 32'h00400010, 32'h00400010,
         32'h00400040);
    chk("rst_cnt_init_idx4", 32'(bus.if_pred_taken), 32'd1);
    chk("post_rst_branch_count", 32'(bus.branch_count), 32'd1);
    step(0, 0, 0, 0, 0, 0, 32'h00400010, 32'h00400010, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage branch resolution unit paired with a 2-bit-counter branch history table (BHT).
- IF side: supplies a taken/not-taken prediction for the fetch PC.
- EX side: compares the carried-down prediction with the actual outcome. Drives the 2-bit Nexttype code consumed by the hazard detector, plus the redirect PC.
- Updates the BHT and keeps saturating branch and mispredict statistics.

Parameters:
- BHT_INDEX_BITS, 4, log2 of BHT entries (16 entries); index = pc[BHT_INDEX_BITS+1:2]
- CNT_INIT, 2'b01, counter reset value (weakly not-taken)
- STAT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_pc  in  32  current fetch PC
- if_pred_taken  out  1  prediction for if_pc (combinational BHT read)
- ex_valid  in  1  EX holds a real instruction (0 for bubble/flushed slot)
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jump  in  1  EX instruction is j/jal
- ex_taken  in  1  actual branch condition result from ALU
- ex_pred_taken  in  1  prediction made at fetch, carried through IF/ID and ID/EX
- ex_pc  in  32  PC of the EX instruction
- ex_target  in  32  computed branch/jump target
- nexttype  out  2  00 PCPlus4, 01 Branch (predicted right), 10 BranchWrong, 11 Jump
- redirect_pc  out  32  PC to fetch on BranchWrong/Jump
- branch_count  out  STAT_WIDTH  resolved conditional branches
- mispredict_count  out  STAT_WIDTH  BranchWrong events

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all BHT counters = CNT_INIT
  - branch_count = 0, mispredict_count = 0
  - if_pred_taken reflects the reset table (0 with default CNT_INIT)
  - nexttype/redirect_pc are combinational: 00 and ex_pc+4 while inputs are idle
- Prediction: if_pred_taken = bht[if_pc index][1]. Zero-cycle latency, no register.
- nexttype, combinational, priority order:
  - ex_valid=0 -> 00
  - ex_is_jump -> 11, redirect_pc = ex_target
  - ex_is_branch and ex_taken == ex_pred_taken -> 01, redirect_pc = ex_pc+4 (unused)
  - ex_is_branch and mismatch -> 10; redirect_pc = ex_target if ex_taken, else ex_pc+4
  - otherwise -> 00
  - ex_is_jump and ex_is_branch both set: jump wins; no BHT update, no count
- BHT update at posedge, only when ex_valid & ex_is_branch & !ex_is_jump & !rst:
  - ex_taken=1 -> counter saturating increment (max 2'b11)
  - ex_taken=0 -> counter saturating decrement (min 2'b00)
  - index taken from ex_pc
- Same-cycle read/write of one index: if_pred_taken returns the pre-update value. No bypass.
- Statistics:
  - branch_count +1 per updating branch
  - mispredict_count +1 per BranchWrong
  - both saturate at all-ones, never wrap
- Flush interaction: the cycle after nexttype=10/11, the hazard detector flushes ID/EX, so ex_valid=0 is required and the unit emits 00. The unit holds no pending state across cycles except BHT and statistics.
- Load-stall bubble: arrives as ex_valid=0 -> 00, no update.
- rst asserted mid-stream: the update in that cycle is suppressed and reset values win.
- Address arithmetic: ex_pc+4 is a 32-bit modulo add; 0xFFFFFFFC+4 = 0x00000000.

Decomposition:
- Shared header/package: Nexttype constants PCPlus4=2'b00, Branch=2'b01, BranchWrong=2'b10, Jump=2'b11. The hazard detector uses the same definitions.
- Sub-module bht_counter_array, which holds:
  - the 2^BHT_INDEX_BITS x 2-bit table
  - one combinational read port
  - one synchronous saturating-update write port with synchronous reset
- Top level holds the resolution logic, redirect mux and statistics.

Test Plan:
- Reset then if_pc=0x00400000 -> if_pred_taken=0. Statistics 0. nexttype=00 with ex_valid=0.
- Branch at ex_pc=0x00400010, pred=0, taken=1, target=0x00400040 -> nexttype=10, redirect_pc=0x00400040. Entry 4 becomes 2'b10. Next cycle if_pc=0x00400010 gives if_pred_taken=1. mispredict_count=1, branch_count=1.
- Same branch taken 3 more times with pred=1 -> nexttype=01 each time. Counter saturates at 2'b11, then one not-taken (pred=1) -> 10, redirect_pc=0x00400014, counter=2'b10.
- Jump at ex_pc=0x00400020, target=0x00401000, ex_is_branch=1 also set -> nexttype=11, redirect_pc=0x00401000. No BHT change, no count change.
- Same-cycle lookup and update of index 4 (if_pc=0x00400010 while resolving that branch) -> if_pred_taken shows the old counter MSB. The new value appears the next cycle.
- Preload mispredict_count to 0xFFFF via repeated mispredicts -> stays 0xFFFF. rst asserted concurrently with a branch update -> table back to 2'b01, counters 0.
